// File: rtl/accel_uart_packetizer.sv
// accel_uart_packetizer
//   Frames filtered accelerometer samples into a fixed byte packet and sends it over an 8N1
//   UART TX line. A new sample is flagged by a rising edge on the filter chip-select, which
//   is synchronized into the clk domain before edge detection.
//
//   Packet: SYNC_BYTE, X[7:0], X[15:8], Y[7:0], Y[15:8], Z[7:0], Z[15:8] [, checksum]
//
//   Optional feature macro: ACCEL_UART_CHECKSUM_EN
//     defined   -> 8-byte packet; the last byte is the XOR of the six data bytes
//     undefined -> 7-byte packet; no checksum logic
//
// Ports
//   clk       base clock, all logic on posedge
//   rst_n     synchronous active-low reset
//   in_cs_n   filter chip-select (async to clk); rising edge = new sample
//   in_x/y/z  16-bit filtered sample, stable from in_cs_n rise to the next rise
//   tx        UART serial out, idle high
//   busy      high from capture until the last stop bit completes
//   drop_cnt  selected samples lost because busy, saturating at 255
//
// CLK_FREQ / BAUD must be >= 4.

module accel_uart_packetizer #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned DECIMATE  = 1,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_cs_n,
  input  logic [15:0] in_x,
  input  logic [15:0] in_y,
  input  logic [15:0] in_z,
  output logic        tx,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned     BaudDiv = CLK_FREQ / BAUD;
  localparam int unsigned     TmrW    = (BaudDiv > 1) ? $clog2(BaudDiv) : 1;
  localparam logic [TmrW-1:0] TmrLast = TmrW'(BaudDiv - 1);
  localparam logic [7:0]      DecLast = 8'(DECIMATE - 1);
`ifdef ACCEL_UART_CHECKSUM_EN
  localparam logic [2:0]      LastByte = 3'd7;
`else
  localparam logic [2:0]      LastByte = 3'd6;
`endif

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic            sync1_q, sync2_q, sync3_q;
  logic [7:0]      dec_cnt_q, dec_cnt_d;
  logic [15:0]     x_q, x_d, y_q, y_d, z_q, z_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [2:0]      byte_idx_q, byte_idx_d;
  logic            busy_q, busy_d;
  logic            tx_q, tx_d;
  logic [7:0]      drop_q, drop_d;

  logic            sample_evt;
  logic            selected;
  logic            bit_end;
  logic            pkt_done;
  logic            can_accept;
  logic            capture;
  logic            drop;
  logic [7:0]      cur_byte;

  assign sample_evt = sync2_q & ~sync3_q;
  assign selected   = sample_evt && (dec_cnt_q == 8'd0);
  assign bit_end    = (tmr_q == TmrLast);
  assign pkt_done   = (state_q == StStop) && bit_end && (byte_idx_q == LastByte);
  // A sample arriving on the edge that ends the last stop bit is taken, not dropped.
  assign can_accept = (state_q == StIdle) || pkt_done;
  assign capture    = selected && can_accept;
  assign drop       = selected && !can_accept;

`ifdef ACCEL_UART_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = x_q[7:0] ^ x_q[15:8] ^ y_q[7:0] ^ y_q[15:8] ^ z_q[7:0] ^ z_q[15:8];
`endif

  // Byte currently on the wire, selected by the byte index.
  always_comb begin
    cur_byte = SYNC_BYTE;
    case (byte_idx_q)
      3'd1:    cur_byte = x_q[7:0];
      3'd2:    cur_byte = x_q[15:8];
      3'd3:    cur_byte = y_q[7:0];
      3'd4:    cur_byte = y_q[15:8];
      3'd5:    cur_byte = z_q[7:0];
      3'd6:    cur_byte = z_q[15:8];
`ifdef ACCEL_UART_CHECKSUM_EN
      3'd7:    cur_byte = csum;
`endif
      default: cur_byte = SYNC_BYTE;
    endcase
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      sync3_q    <= 1'b1;
      dec_cnt_q  <= 8'd0;
      x_q        <= 16'd0;
      y_q        <= 16'd0;
      z_q        <= 16'd0;
      tmr_q      <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= in_cs_n;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      dec_cnt_q  <= dec_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      tmr_q      <= tmr_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      busy_q     <= busy_d;
      tx_q       <= tx_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (capture) state_d = StStart;
      StStart: if (bit_end) state_d = StData;
      StData:  if (bit_end && (bit_idx_q == 3'd7)) state_d = StStop;
      StStop: begin
        if (bit_end) begin
          if (byte_idx_q != LastByte) begin
            state_d = StStart;
          end else begin
            state_d = capture ? StStart : StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: timers, counters, holding registers.
  always_comb begin
    dec_cnt_d  = dec_cnt_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    tmr_d      = tmr_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    busy_d     = busy_q;
    drop_d     = drop_q;

    if (sample_evt) begin
      dec_cnt_d = (dec_cnt_q == DecLast) ? 8'd0 : dec_cnt_q + 8'd1;
    end

    if (capture) begin
      x_d = in_x;
      y_d = in_y;
      z_d = in_z;
    end

    // Timer idles at zero so the first start bit gets a full BAUD_DIV period.
    if ((state_q == StIdle) || bit_end) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TmrW'(1);
    end

    // Wraps 7 -> 0 on the last data bit, ready for the next byte.
    if ((state_q == StData) && bit_end) begin
      bit_idx_d = bit_idx_q + 3'd1;
    end

    if ((state_q == StStop) && bit_end) begin
      byte_idx_d = (byte_idx_q == LastByte) ? 3'd0 : byte_idx_q + 3'd1;
    end

    if (capture) begin
      busy_d = 1'b1;
    end else if (pkt_done) begin
      busy_d = 1'b0;
    end

    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Output logic; tx is registered, so the line trails the state by one clk.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_byte[bit_idx_q];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign drop_cnt = drop_q;

endmodule
